lx32_instr_encoder: RTL and testbench
=====================================

Name: lx32_instr_encoder

Overview:
- Two-stage pipelined RV32I instruction encoder; the inverse of the base-ISA immediate extraction. It takes a format tag, register/function fields and a 32-bit immediate value, and produces the encoded 32-bit instruction word.
- Sits between instruction-synthesis sources (debug program buffer, self-test sequencer) and the fetch/injection path.
- Checks each immediate for range and alignment. Illegal requests are replaced by a canonical NOP and flagged.

Parameters:
- CNT_W, 16, width of the saturating error counter (≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  drop all in-flight entries
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_fmt  in  3  fmt_e: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are illegal
- in_opcode  in  7  opcode[6:0]
- in_rd  in  5  rd
- in_rs1  in  5  rs1
- in_rs2  in  5  rs2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7; R-type only
- in_imm  in  32  immediate as the decoded sign-extended value
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_err  out  2  err_e: 0 none, 1 range, 2 align, 3 bad_fmt
- err_count  out  CNT_W  saturating count of consumed results with out_err≠0

Behaviour:
- Reset (rst_n=0 at posedge): both stage valids 0, out_instr=0, out_err=0, err_count=0. in_ready=0 during reset. Reset mid-operation discards all in-flight entries.
- Handshake and stage enables:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en && !flush
  - Throughput is 1 per cycle. out_valid/out_instr/out_err stay stable while out_valid && !out_ready.
- Latency: an entry accepted at edge N has out_valid at edge N+2 if out_ready stays high.
- Stage 1 (check): registers the fields plus a computed err_e.
  - Priority: bad_fmt > align > range.
  - I and S: range error unless imm[31:11] is all equal.
  - B: align error if imm[0]=1; range error unless imm[31:12] is all equal.
  - J: align error if imm[0]=1; range error unless imm[31:20] is all equal.
  - U: range error if imm[11:0]≠0.
  - R: imm ignored, never an error.
- Stage 2 (pack): field placement.
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - Unused fields for a format are ignored.
  - If err≠0: out_instr=32'h0000_0013 (addi x0,x0,0).
- Round-trip property: for err=0, extracting the immediate of the appropriate format from out_instr equals in_imm, and register/function fields are preserved.
- flush=1 at an edge: both stage valids cleared; no input is accepted that cycle; err_count unchanged. Flush with out_valid && out_ready on the same edge: that result counts as consumed.
- err_count increments on out_valid && out_ready && out_err≠0 and saturates at 2^CNT_W−1. Reset is the only clear.

Decomposition:
- fmt_e, err_e and the NOP constant go in shared package lx32_encode_pkg, which imports lx32_arch_pkg for XLEN/instr_t.
- Per-format field-width constants are reused from the existing immediate-decode package.
- One natural sub-module: lx32_imm_range_check (combinational fmt+imm → err_e), instantiated in stage 1.

Test Plan:
- I-format, op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFF_FFFF (addi x1,x0,-1) -> out_instr=0xFFF0_0093, err=0, exactly 2 cycles after acceptance.
- S-format, op=0x23, rs1=2, rs2=5, f3=2, imm=8 (sw x5,8(x2)) -> 0x0051_2423. Then I-format imm=0x800 -> err=1, instr=0x0000_0013.
- J-format, op=0x6F, rd=1, imm=0x800 -> 0x0010_00EF. Same with imm=0x801 -> err=2 and NOP. fmt=6 with imm=0x801 -> err=3 (priority).
- U-format, op=0x37, rd=5, imm=0x1234_5000 -> 0x1234_52B7. imm=0x1234_5001 -> err=1. Random legal B/J/I/S/U/R stream checked against the decode functions (round-trip).
- Backpressure: 4 back-to-back requests with out_ready held 0 -> exactly 2 accepted, in_ready=0, outputs stable. Release -> all 4 emitted in order, no loss or duplication.
- flush with 2 entries in flight -> out_valid=0 next cycle, err_count unchanged. rst_n=0 mid-stream -> all outputs at reset values. With CNT_W=4, 20 consumed errors -> err_count=15.

Source files
------------

// File: rtl/lx32_arch_pkg.sv
// Architectural basics shared across the lx32 core: data-path width and the
// instruction word type.
package lx32_arch_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] instr_t;

endpackage

// File: rtl/lx32_encode_pkg.sv
// Types and constants for the RV32I instruction encoder: format tags, error
// codes, the canonical NOP, and a sign-extension fit helper.
package lx32_encode_pkg;

  import lx32_arch_pkg::*;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RANGE   = 2'd1,
    ERR_ALIGN   = 2'd2,
    ERR_BAD_FMT = 2'd3
  } err_e;

  // addi x0, x0, 0
  localparam instr_t NOP = 32'h0000_0013;

  // True when every bit from lsb upward equals the sign bit, i.e. the value
  // survives truncation to lsb+1 bits followed by sign extension.
  function automatic logic upper_same(input logic [XLEN-1:0] v,
                                      input int unsigned lsb);
    logic signed [XLEN-1:0] s;
    s = $signed(v) >>> lsb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/lx32_imm_decode_pkg.sv
// Immediate field widths of the RV32I base formats, as seen by the decoder.
// Each width is the number of significant bits of the sign-extended value
// (B and J include the implicit zero LSB; U counts the upper 20 bits only).
package lx32_imm_decode_pkg;

  localparam int IMM_I_W = 12;
  localparam int IMM_S_W = 12;
  localparam int IMM_B_W = 13;
  localparam int IMM_U_W = 20;
  localparam int IMM_J_W = 21;

endpackage

// File: rtl/lx32_imm_range_check.sv
// Combinational legality check of an encode request.
//   fmt : format tag (fmt_e encoding; 6 and 7 are illegal)
//   imm : immediate as the decoded, sign-extended value
//   err : err_e code, priority bad_fmt > align > range
module lx32_imm_range_check
  import lx32_arch_pkg::*, lx32_encode_pkg::*, lx32_imm_decode_pkg::*;
(
  input  logic [2:0]      fmt,
  input  logic [XLEN-1:0] imm,
  output logic [1:0]      err
);

  err_e e;

  always_comb begin
    // NOTE: default assigned first so every path drives e; no latch.
    e = ERR_NONE;
    case (fmt)
      FMT_R: e = ERR_NONE;
      FMT_I: if (!upper_same(imm, IMM_I_W - 1)) e = ERR_RANGE;
      FMT_S: if (!upper_same(imm, IMM_S_W - 1)) e = ERR_RANGE;
      FMT_B: begin
        if (imm[0])                               e = ERR_ALIGN;
        else if (!upper_same(imm, IMM_B_W - 1))   e = ERR_RANGE;
      end
      FMT_J: begin
        if (imm[0])                               e = ERR_ALIGN;
        else if (!upper_same(imm, IMM_J_W - 1))   e = ERR_RANGE;
      end
      FMT_U: if (imm[XLEN-IMM_U_W-1:0] != '0) e = ERR_RANGE;
      default: e = ERR_BAD_FMT;
    endcase
  end

  assign err = e;

endmodule

// File: rtl/lx32_instr_encoder.sv
// Two-stage pipelined RV32I instruction encoder.
//   Stage 1 registers the request fields and its legality code.
//   Stage 2 packs the fields into an instruction word (NOP when illegal).
// Ports:
//   clk, rst_n (synchronous, active low), flush (drops in-flight entries)
//   in_valid/in_ready + in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
//     in_funct3, in_funct7, in_imm           : request channel
//   out_valid/out_ready + out_instr, out_err  : result channel
//   err_count : saturating count of consumed results with out_err != 0
module lx32_instr_encoder
  import lx32_arch_pkg::*, lx32_encode_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] err_count
);

  logic        s1_valid, s2_valid;
  logic        s1_en, s2_en, accept;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode, s1_funct7;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_funct3;
  instr_t      s1_imm;
  logic [1:0]  s1_err, chk_err;
  instr_t      s2_instr, packed_instr;
  logic [1:0]  s2_err;

  assign s2_en    = !s2_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en && !flush && rst_n;
  assign accept   = in_valid && in_ready;

  lx32_imm_range_check u_chk (
    .fmt (in_fmt),
    .imm (in_imm),
    .err (chk_err)
  );

  // Stage 1 occupancy.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of process ordering.
    if (!rst_n)     s1_valid <= 1'b0;
    else if (flush) s1_valid <= 1'b0;
    else if (s1_en) s1_valid <= accept;
  end

  // Stage 1 payload.
  // NOTE: payload registers carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_fmt    <= in_fmt;
      s1_opcode <= in_opcode;
      s1_rd     <= in_rd;
      s1_rs1    <= in_rs1;
      s1_rs2    <= in_rs2;
      s1_funct3 <= in_funct3;
      s1_funct7 <= in_funct7;
      s1_imm    <= in_imm;
      s1_err    <= chk_err;
    end
  end

  always_comb begin
    packed_instr = NOP;
    if (s1_err == ERR_NONE) begin
      case (s1_fmt)
        FMT_R: packed_instr = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
        FMT_I: packed_instr = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        FMT_S: packed_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                               s1_imm[4:0], s1_opcode};
        FMT_B: packed_instr = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                               s1_imm[4:1], s1_imm[11], s1_opcode};
        FMT_U: packed_instr = {s1_imm[31:12], s1_rd, s1_opcode};
        FMT_J: packed_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                               s1_rd, s1_opcode};
        default: packed_instr = NOP;
      endcase
    end
  end

  // Stage 2: output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= ERR_NONE;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= packed_instr;
        s2_err   <= s1_err;
      end
    end
  end

  // A result consumed on a flush edge still counts.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= '0;
    else if (s2_valid && out_ready && (s2_err != ERR_NONE) && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_lx32_instr_encoder.sv
// Directed and randomized-legal stimulus for lx32_instr_encoder (CNT_W=4).
module tb_lx32_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr;
  logic [1:0]  out_err;
  logic [3:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lx32_instr_encoder #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic [1:0]  exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] ei, input logic [1:0] ee);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  // Independent RV32I decode of out_instr against the original request.
  function automatic logic rt_ok(input vec_t r, input logic [31:0] i);
    logic [31:0] imm;
    logic ok;
    ok = (i[6:0] == r.op);
    case (r.fmt)
      3'd0: ok = ok && i[11:7] == r.rd && i[14:12] == r.f3 && i[19:15] == r.rs1
                 && i[24:20] == r.rs2 && i[31:25] == r.f7;
      3'd1: begin
        imm = {{20{i[31]}}, i[31:20]};
        ok = ok && i[11:7] == r.rd && i[14:12] == r.f3 && i[19:15] == r.rs1 && imm == r.imm;
      end
      3'd2: begin
        imm = {{20{i[31]}}, i[31:25], i[11:7]};
        ok = ok && i[14:12] == r.f3 && i[19:15] == r.rs1 && i[24:20] == r.rs2 && imm == r.imm;
      end
      3'd3: begin
        imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        ok = ok && i[14:12] == r.f3 && i[19:15] == r.rs1 && i[24:20] == r.rs2 && imm == r.imm;
      end
      3'd4: begin
        imm = {i[31:12], 12'h000};
        ok = ok && i[11:7] == r.rd && imm == r.imm;
      end
      default: begin
        imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        ok = ok && i[11:7] == r.rd && imm == r.imm;
      end
    endcase
    return ok;
  endfunction

  function automatic vec_t rand_legal();
    vec_t v;
    logic [31:0] r;
    r = $urandom;
    v = mk(3'($urandom_range(0, 5)), 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), 7'($urandom), r, 32'h0, 2'd0);
    case (v.fmt)
      3'd1, 3'd2: v.imm = {{20{r[11]}}, r[11:0]};
      3'd3:       v.imm = {{19{r[12]}}, r[12:1], 1'b0};
      3'd4:       v.imm = {r[31:12], 12'h000};
      3'd5:       v.imm = {{11{r[20]}}, r[20:1], 1'b0};
      default:    v.imm = r;
    endcase
    return v;
  endfunction

  // Single request into an empty pipe, out_ready high; checks latency and result.
  task automatic run_vec(input int k, input vec_t v);
    drive(v);
    in_valid = 1'b1;
    #1 check($sformatf("v%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
    @(negedge clk);                // acceptance edge N passed
    in_valid = 1'b0;
    #1 check($sformatf("v%0d_valid_n1", k), {31'd0, out_valid}, 32'd0);
    @(negedge clk);                // edge N+1 passed; consumed at N+2
    #1 check($sformatf("v%0d_valid_n2", k), {31'd0, out_valid}, 32'd1);
    check($sformatf("v%0d_instr", k), out_instr, v.exp_instr);
    check($sformatf("v%0d_err", k), {30'd0, out_err}, {30'd0, v.exp_err});
    @(negedge clk);
  endtask

  initial begin
    vec_t bp[4];
    vec_t rq[60];
    vec_t exp_q[$];
    vec_t e;
    vec_t err_req;
    int idx, got;
    logic [3:0] cnt_before;

    vecs[0]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
    vecs[1]  = mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'h0000_0008, 32'h0051_2423, 2'd0);
    vecs[2]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 2'd1);
    vecs[3]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 2'd0);
    vecs[4]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0801, 32'h0000_0013, 2'd2);
    vecs[5]  = mk(3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0801, 32'h0000_0013, 2'd3);
    vecs[6]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    vecs[7]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 2'd1);
    vecs[8]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 2'd0);
    vecs[9]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 2'd0);
    vecs[10] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_0013, 2'd1);
    vecs[11] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 2'd2);
    vecs[12] = mk(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0013, 2'd3);
    vecs[13] = mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_F800, 32'h8051_2023, 2'd0);
    err_req  = vecs[2];

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    @(negedge clk); @(negedge clk);
    #1 check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {30'd0, out_err}, 32'd0);
    check("rst_err_count", {28'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);
    #1 check("tbl_err_count", {28'd0, err_count}, 32'd7);

    // Backpressure: out_ready low, four back-to-back requests.
    for (int k = 0; k < 4; k++)
      bp[k] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1),
                 (32'(k + 1) << 20) | 32'h93, 2'd0);
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) drive(bp[idx]);
      #1 if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b1;
    #1 check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_instr", out_instr, bp[0].exp_instr);
    @(negedge clk);
    #1 check("bp_hold_instr2", out_instr, bp[0].exp_instr);
    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) drive(bp[idx]);
      #1;
      if (out_valid) begin
        check($sformatf("bp_order%0d", got), out_instr, bp[got].exp_instr);
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_emitted", 32'(got), 32'd4);
    @(negedge clk);
    #1 check("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // Random legal stream with random backpressure; round-trip decode.
    for (int k = 0; k < 60; k++) rq[k] = rand_legal();
    idx = 0; got = 0;
    for (int c = 0; c < 600 && got < 60; c++) begin
      in_valid  = (idx < 60) && ($urandom_range(0, 3) != 0);
      if (idx < 60) drive(rq[idx]);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rt_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rt%0d_ok", got), {31'd0, rt_ok(e, out_instr)}, 32'd1);
          check($sformatf("rt%0d_err", got), {30'd0, out_err}, 32'd0);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(rq[idx]);
        idx++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rt_count", 32'(got), 32'd60);
    @(negedge clk);

    // Flush on the same edge as a consumed error result: it still counts.
    drive(err_req); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 check("fc_valid", {31'd0, out_valid}, 32'd1);
    cnt_before = err_count;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("fc_count", {28'd0, err_count}, {28'd0, cnt_before + 4'd1});
    check("fc_valid_after", {31'd0, out_valid}, 32'd0);

    // Flush with two stalled entries in flight.
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 6 && idx < 2; c++) begin
      in_valid = 1'b1;
      #1 if (in_ready) idx++;
      @(negedge clk);
    end
    check("fl_loaded", 32'(idx), 32'd2);
    cnt_before = err_count;
    flush = 1'b1; in_valid = 1'b1;
    #1 check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_count", {28'd0, err_count}, {28'd0, cnt_before});
    @(negedge clk); @(negedge clk);
    #1 check("fl_s1_cleared", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream.
    drive(vecs[0]); out_ready = 1'b0; in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1 check("mr_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_out_instr", out_instr, 32'd0);
    check("mr_out_err", {30'd0, out_err}, 32'd0);
    check("mr_err_count", {28'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 check("mr_pipe_empty", {31'd0, out_valid}, 32'd0);

    // Saturation: 20 consumed errors on a 4-bit counter.
    drive(err_req); idx = 0;
    for (int c = 0; c < 60 && idx < 20; c++) begin
      in_valid = 1'b1;
      #1 if (in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sat_sent", 32'(idx), 32'd20);
    for (int c = 0; c < 4; c++) @(negedge clk);
    #1 check("sat_count", {28'd0, err_count}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
